// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer_if
//  Purpose  : Bundles the instruction-memory handshake, the decode-side
//             hand-off and the status outputs of the fetch sequencer.
//  Modports : master - the fetch sequencer (drives req/addr/instr/pc/...)
//             slave  - the environment (memory + decode/execute stage)
//  Signals  : imem_req, imem_addr[31:0], imem_ready, imem_rdata[31:0],
//             instr[31:0], instr_valid, instr_accept, pcsel,
//             branch_off[31:0], jump, jump_target[25:0], pc[31:0], trap,
//             retired[31:0]
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_accept;
   logic        pcsel;
   logic [31:0] branch_off;
   logic        jump;
   logic [25:0] jump_target;
   logic [31:0] pc;
   logic        trap;
   logic [31:0] retired;

   modport master (
      output imem_req, imem_addr,
      input  imem_ready, imem_rdata,
      output instr, instr_valid,
      input  instr_accept, pcsel, branch_off, jump, jump_target,
      output pc, trap, retired
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ready, imem_rdata,
      input  instr, instr_valid,
      output instr_accept, pcsel, branch_off, jump, jump_target,
      input  pc, trap, retired
   );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Fetch-side controller for the unpipelined MIPS core. Owns the
//             PC, issues instruction-memory reads over a req/ready
//             handshake, holds each fetched word until decode accepts it,
//             then advances the PC (sequential, branch or jump). Traps to
//             TRAP_VEC when memory does not answer within MAX_WAIT cycles.
//  Ports    : clk   - system clock, rising edge
//             reset - asynchronous, active-low reset
//             bus   - fetch_sequencer_if.master (memory handshake, decode
//                     hand-off, pc / trap / retired status)
//  Params   : RESET_VEC - PC after reset (word address)
//             TRAP_VEC  - PC after a fetch timeout (word address)
//             MAX_WAIT  - REQ cycles without ready before trapping (1..255)
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0040,
   parameter int unsigned MAX_WAIT  = 15
) (
   input  logic              clk,
   input  logic              reset,
   fetch_sequencer_if.master bus
);

   // Last wait-counter value that may still be followed by another REQ
   // cycle; a miss while the counter holds this value is the MAX_WAIT-th.
   localparam logic [7:0] c_wait_last = 8'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2,
      ST_TRAP = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic        r_armed;        // IDLE has seen its first edge after reset
   logic        w_armed_next;
   logic [31:0] r_pc;
   logic [31:0] w_pc_next;
   logic [31:0] r_instr;
   logic [31:0] w_instr_next;
   logic [7:0]  r_wait;
   logic [7:0]  w_wait_next;
   logic [31:0] r_retired;
   logic [31:0] w_retired_next;

   logic        r_imem_req;
   logic        r_instr_valid;
   logic        r_trap;

   logic [31:0] w_pc_seq;
   logic [31:0] w_pc_branch;
   logic [31:0] w_pc_jump;

   // Candidate next-PC values; selection happens only on an accepted HOLD.
   assign w_pc_seq    = r_pc + 32'd1;
   assign w_pc_branch = w_pc_seq + bus.branch_off;
   assign w_pc_jump   = {r_pc[31:26], bus.jump_target};

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and next-datapath logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next   = r_state;
      w_armed_next   = r_armed;
      w_pc_next      = r_pc;
      w_instr_next   = r_instr;
      w_wait_next    = r_wait;
      w_retired_next = r_retired;

      case (r_state)
         // IDLE spans two edges so that the first request appears on the
         // second rising edge after reset release.
         ST_IDLE: begin
            if (r_armed) begin
               w_state_next = ST_REQ;
            end else begin
               w_armed_next = 1'b1;
            end
         end

         // A ready on the MAX_WAIT-th cycle wins over the timeout because
         // the ready test comes first.
         ST_REQ: begin
            if (bus.imem_ready) begin
               w_instr_next = bus.imem_rdata;
               w_wait_next  = 8'd0;
               w_state_next = ST_HOLD;
            end else if (r_wait == c_wait_last) begin
               w_wait_next  = r_wait + 8'd1;
               w_state_next = ST_TRAP;
            end else begin
               w_wait_next  = r_wait + 8'd1;
            end
         end

         // Redirect inputs are only meaningful together with instr_accept.
         ST_HOLD: begin
            if (bus.instr_accept) begin
               if (bus.jump) begin
                  w_pc_next = w_pc_jump;
               end else if (bus.pcsel) begin
                  w_pc_next = w_pc_branch;
               end else begin
                  w_pc_next = w_pc_seq;
               end
               w_retired_next = r_retired + 32'd1;
               w_state_next   = ST_REQ;
            end
         end

         ST_TRAP: begin
            w_pc_next    = TRAP_VEC;
            w_wait_next  = 8'd0;
            w_state_next = ST_REQ;
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath and registered outputs. Status outputs are decoded from the
   // next state so they line up with the state they describe.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_armed       <= 1'b0;
         r_pc          <= RESET_VEC;
         r_instr       <= 32'd0;
         r_wait        <= 8'd0;
         r_retired     <= 32'd0;
         r_imem_req    <= 1'b0;
         r_instr_valid <= 1'b0;
         r_trap        <= 1'b0;
      end else begin
         r_armed       <= w_armed_next;
         r_pc          <= w_pc_next;
         r_instr       <= w_instr_next;
         r_wait        <= w_wait_next;
         r_retired     <= w_retired_next;
         r_imem_req    <= (w_state_next == ST_REQ);
         r_instr_valid <= (w_state_next == ST_HOLD);
         r_trap        <= (w_state_next == ST_TRAP);
      end
   end

   assign bus.imem_req    = r_imem_req;
   assign bus.imem_addr   = r_pc;
   assign bus.instr       = r_instr;
   assign bus.instr_valid = r_instr_valid;
   assign bus.pc          = r_pc;
   assign bus.trap        = r_trap;
   assign bus.retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Purpose  : Directed self-checking bench for fetch_sequencer. Expected
//             fetch addresses are queued when a redirect is driven and
//             compared when the next request appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

   logic clk = 1'b0;
   logic reset;

   fetch_sequencer_if bus ();

   fetch_sequencer #(
      .RESET_VEC (32'h0000_0000),
      .TRAP_VEC  (32'h0000_0040),
      .MAX_WAIT  (15)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_retired;

   // Memory contents are a fixed function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
   endfunction

   assign bus.imem_rdata = mem_word(bus.imem_addr);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_ctl();
      bus.imem_ready   = 1'b0;
      bus.instr_accept = 1'b0;
      bus.pcsel        = 1'b0;
      bus.jump         = 1'b0;
      bus.branch_off   = 32'd0;
      bus.jump_target  = 26'd0;
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_req"},     {31'd0, bus.imem_req},    32'd0);
      chk({tag, "_valid"},   {31'd0, bus.instr_valid}, 32'd0);
      chk({tag, "_trap"},    {31'd0, bus.trap},        32'd0);
      chk({tag, "_pc"},      bus.pc,                   32'd0);
      chk({tag, "_instr"},   bus.instr,                32'd0);
      chk({tag, "_retired"}, bus.retired,              32'd0);
   endtask

   // One complete fetch starting in REQ: optional ready delay, optional
   // backpressure in HOLD, then accept with the given redirect.
   task automatic do_fetch(input int waits, input int stalls, input logic j,
                           input logic ps, input logic [31:0] off,
                           input logic [25:0] tgt);
      logic [31:0] a;
      logic [31:0] nxt;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty: observed 0 entries expected 1");
         return;
      end
      a = exp_q.pop_front();
      chk("fetch_addr", bus.imem_addr, a);
      chk("fetch_req", {31'd0, bus.imem_req}, 32'd1);
      for (int i = 0; i < waits; i++) begin
         bus.imem_ready   = 1'b0;
         bus.instr_accept = 1'b1;   // ignored outside HOLD
         bus.jump         = 1'b1;
         step();
         chk("wait_trap",    {31'd0, bus.trap},     32'd0);
         chk("wait_req",     {31'd0, bus.imem_req}, 32'd1);
         chk("wait_addr",    bus.imem_addr,         a);
         chk("wait_retired", bus.retired,           exp_retired);
      end
      clear_ctl();
      bus.imem_ready = 1'b1;
      step();
      bus.imem_ready = 1'b0;
      chk("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("hold_instr", bus.instr, mem_word(a));
      chk("hold_req",   {31'd0, bus.imem_req}, 32'd0);
      chk("hold_trap",  {31'd0, bus.trap}, 32'd0);
      for (int i = 0; i < stalls; i++) begin
         bus.pcsel       = i[0];
         bus.jump        = i[1];
         bus.branch_off  = 32'h0000_0100;
         bus.jump_target = 26'h3FF_FFFF;
         step();
         chk("stall_instr",   bus.instr, mem_word(a));
         chk("stall_pc",      bus.pc, a);
         chk("stall_retired", bus.retired, exp_retired);
         chk("stall_valid",   {31'd0, bus.instr_valid}, 32'd1);
      end
      if (j)       nxt = {a[31:26], tgt};
      else if (ps) nxt = a + 32'd1 + off;
      else         nxt = a + 32'd1;
      exp_q.push_back(nxt);
      exp_retired++;
      bus.instr_accept = 1'b1;
      bus.jump         = j;
      bus.pcsel        = ps;
      bus.branch_off   = off;
      bus.jump_target  = tgt;
      step();
      clear_ctl();
      chk("accept_retired", bus.retired, exp_retired);
      chk("accept_valid",   {31'd0, bus.instr_valid}, 32'd0);
      chk("accept_req",     {31'd0, bus.imem_req}, 32'd1);
   endtask

   task automatic release_and_restart();
      #2 reset = 1'b1;
      step();
      chk("restart_idle_req", {31'd0, bus.imem_req}, 32'd0);
      step();
      chk("restart_req",  {31'd0, bus.imem_req}, 32'd1);
      chk("restart_addr", bus.imem_addr, 32'd0);
      exp_q.delete();
      exp_q.push_back(32'd0);
      exp_retired = 32'd0;
   endtask

   initial begin
      logic [31:0] a;
      reset = 1'b0;
      clear_ctl();
      exp_retired = 32'd0;
      step();
      step();
      check_cleared("reset");

      // Release away from a clock edge; first request on the second edge.
      reset = 1'b1;
      step();
      chk("idle_quiet_req", {31'd0, bus.imem_req}, 32'd0);
      step();
      chk("first_req",  {31'd0, bus.imem_req}, 32'd1);
      chk("first_addr", bus.imem_addr, 32'd0);
      exp_q.push_back(32'd0);

      // Sequential fetch 0..3
      repeat (4) do_fetch(0, 0, 1'b0, 1'b0, 32'd0, 26'd0);
      chk("retired_after_4", bus.retired, 32'd4);

      // Backward branch at 5, forward branch at 5
      do_fetch(0, 0, 1'b0, 1'b0, 32'd0, 26'd0);                 // 4 -> 5
      do_fetch(0, 0, 1'b0, 1'b1, 32'hFFFF_FFFD, 26'd0);         // 5 -> 3
      chk("branch_back_addr", bus.imem_addr, 32'd3);
      do_fetch(0, 0, 1'b0, 1'b0, 32'd0, 26'd0);                 // 3 -> 4
      do_fetch(0, 0, 1'b0, 1'b0, 32'd0, 26'd0);                 // 4 -> 5
      do_fetch(0, 0, 1'b0, 1'b1, 32'd10, 26'd0);                // 5 -> 16
      chk("branch_fwd_addr", bus.imem_addr, 32'd16);

      // Jump beats branch
      do_fetch(0, 0, 1'b0, 1'b1, 32'h1400_0007 - 32'd17, 26'd0); // -> 0x14000007
      do_fetch(0, 0, 1'b1, 1'b1, 32'd5, 26'h000_0123);
      chk("jump_addr", bus.imem_addr, 32'h1400_0123);

      // Backpressure with toggling redirect inputs
      do_fetch(0, 5, 1'b0, 1'b0, 32'd0, 26'd0);                 // -> 0x14000124
      do_fetch(0, 0, 1'b0, 1'b1, 32'd9 - 32'h1400_0125, 26'd0); // -> 9

      // Timeout at pc=9
      a = exp_q.pop_front();
      chk("to_addr", bus.imem_addr, a);
      repeat (14) begin
         step();
         chk("to_wait_trap", {31'd0, bus.trap}, 32'd0);
         chk("to_wait_req",  {31'd0, bus.imem_req}, 32'd1);
      end
      step();
      chk("to_trap_pulse", {31'd0, bus.trap}, 32'd1);
      chk("to_trap_req",   {31'd0, bus.imem_req}, 32'd0);
      chk("to_retired",    bus.retired, exp_retired);
      step();
      chk("to_trap_end",   {31'd0, bus.trap}, 32'd0);
      chk("to_vec_req",    {31'd0, bus.imem_req}, 32'd1);
      chk("to_vec_addr",   bus.imem_addr, 32'h0000_0040);
      exp_q.push_back(32'h0000_0040);

      // Ready on the 15th cycle: no trap
      do_fetch(0, 0, 1'b0, 1'b1, 32'd9 - 32'h41, 26'd0);        // 0x40 -> 9
      do_fetch(14, 0, 1'b0, 1'b0, 32'd0, 26'd0);                // 9 -> 10
      do_fetch(0, 0, 1'b0, 1'b1, 32'hFFFF_FFFC, 26'd0);         // 10 -> 7

      // Asynchronous reset mid-REQ at pc=7
      a = exp_q.pop_front();
      chk("rst_req_addr", bus.imem_addr, 32'd7);
      #2 reset = 1'b0;
      #1 check_cleared("rst_mid_req");
      release_and_restart();

      // Asynchronous reset mid-HOLD at pc=7
      do_fetch(0, 0, 1'b0, 1'b1, 32'd6, 26'd0);                 // 0 -> 7
      a = exp_q.pop_front();
      bus.imem_ready = 1'b1;
      step();
      bus.imem_ready = 1'b0;
      chk("rst_hold_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("rst_hold_pc",    bus.pc, a);
      #2 reset = 1'b0;
      #1 check_cleared("rst_mid_hold");
      release_and_restart();
      do_fetch(0, 0, 1'b0, 1'b0, 32'd0, 26'd0);
      chk("final_addr", bus.imem_addr, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
